// File: rtl/wb_load_stage_pkg.sv
// Shared definitions for the MEM/WB load-return stage.
// WB FSM encodings, the data-read-enable (DRESEL) bus layout, the lane
// patterns accepted by the load aligner and the architectural reset PC.
// Optional feature macro used by the top: WB_DEBUG_TRACE_EN.
package wb_load_stage_pkg;

   // Write-back stage state: idle, load outstanding, flushed load still owed a response
   typedef enum logic [1:0] {
      WB_IDLE  = 2'b00,
      WB_WAIT  = 2'b01,
      WB_DRAIN = 2'b10
   } wb_state_e;

   // DRESEL bus: [4] = zero-extend, [3:0] = byte lanes ([3] is address offset 0)
   localparam int DRESEL_W = 5;
   typedef logic [DRESEL_W-1:0] dresel_t;

   // Legal lane patterns on dre[3:0]
   localparam logic [3:0] DRE_BYTE0 = 4'b1000;
   localparam logic [3:0] DRE_BYTE1 = 4'b0100;
   localparam logic [3:0] DRE_BYTE2 = 4'b0010;
   localparam logic [3:0] DRE_BYTE3 = 4'b0001;
   localparam logic [3:0] DRE_HALF0 = 4'b1100;
   localparam logic [3:0] DRE_HALF1 = 4'b0011;
   localparam logic [3:0] DRE_WORD  = 4'b1111;

   // PC presented on wb_pc_o while in reset (MIPS boot vector)
   localparam logic [31:0] PC_INIT = 32'hBFC0_0000;

   // True when the access asks for zero-extension instead of sign-extension
   function automatic logic dre_zext(input dresel_t dre);
      return dre[4];
   endfunction

endpackage

// File: rtl/wb_load_stage_load_align.sv
// Load data aligner: selects the byte/half/word addressed by the lane mask
// from a little-endian bus word and sign- or zero-extends it to DATA_W.
// Pure combinational; an unrecognised lane mask yields zero.
module load_align
   import wb_load_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [4:0]        dre,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] data
);

   logic [15:0] field;
   logic        is_byte;
   logic        is_half;
   logic        is_word;
   logic        fill;

   // Pick the addressed lanes, classify the access size, then extend
   always_comb begin
      field   = 16'h0000;
      is_byte = 1'b0;
      is_half = 1'b0;
      is_word = 1'b0;
      case (dre[3:0])
         DRE_BYTE0: begin field = {8'h00, rdata[7:0]};   is_byte = 1'b1; end
         DRE_BYTE1: begin field = {8'h00, rdata[15:8]};  is_byte = 1'b1; end
         DRE_BYTE2: begin field = {8'h00, rdata[23:16]}; is_byte = 1'b1; end
         DRE_BYTE3: begin field = {8'h00, rdata[31:24]}; is_byte = 1'b1; end
         DRE_HALF0: begin field = rdata[15:0];           is_half = 1'b1; end
         DRE_HALF1: begin field = rdata[31:16];          is_half = 1'b1; end
         DRE_WORD:  begin                                is_word = 1'b1; end
         default:   begin                                                end
      endcase
      fill = ~dre_zext(dre) & (is_byte ? field[7] : field[15]);
      if (is_word)
         data = rdata;
      else if (is_half)
         data = {{(DATA_W-16){fill}}, field};
      else if (is_byte)
         data = {{(DATA_W-8){fill}}, field[7:0]};
      else
         data = '0;
   end

endmodule

// File: rtl/wb_load_stage.sv
// MEM/WB pipeline register with load-return unit.
// Non-load instructions pass from MEM to the WB outputs with one cycle of
// latency. A load parks its destination info in pending registers, holds the
// upstream pipeline via stall_req_o, and commits the aligned bus data when
// data_data_ok arrives. A flush while waiting turns the load into a drain
// that swallows the owed response without writing anything.
// Handshake: data_data_ok is a one-cycle valid pulse with no ready; it is
// consumed only in WAIT/DRAIN and ignored in IDLE (store responses belong
// to MEM).
// Optional: define WB_DEBUG_TRACE_EN to add the debug_wb_* trace outputs.
module wb_load_stage
   import wb_load_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int RA_W   = 5,
   parameter int PC_W   = 32
) (
   input  logic                cpu_clk_50M,
   input  logic                cpu_rst,
   input  logic                flush_i,
   input  logic                mem_valid_i,
   input  logic [PC_W-1:0]     mem_pc_i,
   input  logic [RA_W-1:0]     mem_wa_i,
   input  logic                mem_wreg_i,
   input  logic [DATA_W-1:0]   mem_dreg_i,
   input  logic                mem_mreg_i,
   input  logic [4:0]          mem_dre_i,
   input  logic                mem_msext_i,
   input  logic                mem_whilo_i,
   input  logic                mem_whi_i,
   input  logic                mem_wlo_i,
   input  logic [2*DATA_W-1:0] mem_hilo_i,
   input  logic                mem_cp0_we_i,
   input  logic [RA_W-1:0]     mem_cp0_wa_i,
   input  logic [DATA_W-1:0]   mem_cp0_wd_i,
   input  logic                data_data_ok,
   input  logic [DATA_W-1:0]   data_rdata,
   output logic                stall_req_o,
   output logic [RA_W-1:0]     wb_wa_o,
   output logic                wb_wreg_o,
   output logic [DATA_W-1:0]   wb_wd_o,
   output logic                wb_whilo_o,
   output logic                wb_whi_o,
   output logic                wb_wlo_o,
   output logic [2*DATA_W-1:0] wb_hilo_o,
   output logic                wb_cp0_we_o,
   output logic [RA_W-1:0]     wb_cp0_wa_o,
   output logic [DATA_W-1:0]   wb_cp0_wd_o,
   output logic [PC_W-1:0]     wb_pc_o
`ifdef WB_DEBUG_TRACE_EN
   ,
   output logic [PC_W-1:0]     debug_wb_pc,
   output logic [3:0]          debug_wb_rf_wen,
   output logic [RA_W-1:0]     debug_wb_rf_wnum,
   output logic [DATA_W-1:0]   debug_wb_rf_wdata
`endif
);

   // FSM state, visible to bound checkers by name
   wb_state_e         state;

   // Destination info of the load whose response is outstanding
   logic [RA_W-1:0]   pend_wa;
   logic              pend_wreg;
   dresel_t           pend_dre;
   logic [PC_W-1:0]   pend_pc;

   logic [DATA_W-1:0] align_data;

   // mem_msext_i duplicates mem_dre_i[4], which is the authoritative copy
   logic              unused_msext;
   assign unused_msext = mem_msext_i;

   load_align #(.DATA_W(DATA_W)) u_load_align (
      .dre   (pend_dre),
      .rdata (data_rdata),
      .data  (align_data)
   );

   // Upstream stages hold whenever a load (live or flushed) is still owed data
   always_comb begin
      stall_req_o = (state != WB_IDLE);
   end

   // WB pipeline register, pending-load capture and load-return FSM
   always_ff @(posedge cpu_clk_50M) begin
      if (cpu_rst) begin
         state       <= WB_IDLE;
         pend_wa     <= '0;
         pend_wreg   <= 1'b0;
         pend_dre    <= '0;
         pend_pc     <= '0;
         wb_wa_o     <= '0;
         wb_wreg_o   <= 1'b0;
         wb_wd_o     <= '0;
         wb_whilo_o  <= 1'b0;
         wb_whi_o    <= 1'b0;
         wb_wlo_o    <= 1'b0;
         wb_hilo_o   <= '0;
         wb_cp0_we_o <= 1'b0;
         wb_cp0_wa_o <= '0;
         wb_cp0_wd_o <= '0;
         wb_pc_o     <= PC_W'(PC_INIT);
      end else begin
         // Write enables default low; data fields hold their last value
         wb_wreg_o   <= 1'b0;
         wb_whilo_o  <= 1'b0;
         wb_cp0_we_o <= 1'b0;
         case (state)
            WB_IDLE: begin
               if (mem_valid_i && !flush_i) begin
                  if (mem_mreg_i) begin
                     pend_wa   <= mem_wa_i;
                     pend_wreg <= mem_wreg_i;
                     pend_dre  <= mem_dre_i;
                     pend_pc   <= mem_pc_i;
                     state     <= WB_WAIT;
                  end else begin
                     wb_wa_o     <= mem_wa_i;
                     wb_wreg_o   <= mem_wreg_i;
                     wb_wd_o     <= mem_dreg_i;
                     wb_whilo_o  <= mem_whilo_i;
                     wb_whi_o    <= mem_whi_i;
                     wb_wlo_o    <= mem_wlo_i;
                     wb_hilo_o   <= mem_hilo_i;
                     wb_cp0_we_o <= mem_cp0_we_i;
                     wb_cp0_wa_o <= mem_cp0_wa_i;
                     wb_cp0_wd_o <= mem_cp0_wd_i;
                     wb_pc_o     <= mem_pc_i;
                  end
               end
            end
            WB_WAIT: begin
               if (data_data_ok) begin
                  // A flush arriving with the data kills the write but still ends the load
                  if (!flush_i) begin
                     wb_wa_o   <= pend_wa;
                     wb_wreg_o <= pend_wreg;
                     wb_wd_o   <= align_data;
                     wb_pc_o   <= pend_pc;
                  end
                  state <= WB_IDLE;
               end else if (flush_i) begin
                  state <= WB_DRAIN;
               end
            end
            WB_DRAIN: begin
               if (data_data_ok)
                  state <= WB_IDLE;
            end
            default: begin
               state <= WB_IDLE;
            end
         endcase
      end
   end

`ifdef WB_DEBUG_TRACE_EN
   // Commit trace mirrors the registered register-file write, blanked for $0
   logic trace_live;
   always_comb begin
      trace_live        = (wb_wa_o != '0);
      debug_wb_pc       = trace_live ? wb_pc_o : '0;
      debug_wb_rf_wen   = trace_live ? {4{wb_wreg_o}} : 4'b0000;
      debug_wb_rf_wnum  = trace_live ? wb_wa_o : '0;
      debug_wb_rf_wdata = trace_live ? wb_wd_o : '0;
   end
`endif

endmodule
